// File: rtl/ram_sync_wxd.sv
// Parametrised single-port synchronous RAM with a registered read and a valid strobe.
// After reset, a hardware sweep zeroes every word. An out-of-range access raises err.
module ram_sync_wxd #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ABITS = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] entrada,
    input  logic [ABITS-1:0] a,
    input  logic             rw,
    input  logic             en,
    output logic [WIDTH-1:0] s,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    typedef enum logic {INIT, READY} state_t;

    state_t           state;
    logic [ABITS-1:0] cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range;

    // A non-power-of-two DEPTH leaves the top of the address space unmapped.
    assign in_range = (32'(a) < DEPTH);

    always_ff @(posedge clk) begin
        if (!clear) begin
            state <= INIT;
            cnt   <= '0;
            s     <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    mem[cnt] <= '0;
                    s        <= '0;
                    valid    <= 1'b0;
                    err      <= 1'b0;
                    if (cnt == ABITS'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    valid <= 1'b0;
                    err   <= 1'b0;
                    if (en) begin
                        if (!in_range) begin
                            err <= 1'b1;
                            if (!rw) begin
                                s     <= '0;
                                valid <= 1'b1;
                            end
                        end else if (rw) begin
                            mem[a] <= entrada;
                        end else begin
                            s     <= mem[a];
                            valid <= 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sync_wxd.sv
// Directed bench for ram_sync_wxd: a vector table for the 8x8 instance
// and a hand-written sequence for a 16x5 instance with unmapped addresses.
module tb_ram_sync_wxd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8 x 8 instance
    logic       clr8 = 1'b0, rw8 = 1'b0, en8 = 1'b0;
    logic [7:0] din8 = '0, s8;
    logic [2:0] a8 = '0;
    logic       v8, b8, e8;

    ram_sync_wxd #(.WIDTH(8), .DEPTH(8), .ABITS(3)) dut8 (
        .clk(clk), .clear(clr8), .entrada(din8), .a(a8), .rw(rw8), .en(en8),
        .s(s8), .valid(v8), .busy(b8), .err(e8)
    );

    // 16 x 5 instance
    logic        clr16 = 1'b0, rw16 = 1'b0, en16 = 1'b0;
    logic [15:0] din16 = '0, s16;
    logic [2:0]  a16 = '0;
    logic        v16, b16, e16;

    ram_sync_wxd #(.WIDTH(16), .DEPTH(5), .ABITS(3)) dut16 (
        .clk(clk), .clear(clr16), .entrada(din16), .a(a16), .rw(rw16), .en(en16),
        .s(s16), .valid(v16), .busy(b16), .err(e16)
    );

    typedef struct {
        string      name;
        logic       clear;
        logic       en;
        logic       rw;
        logic [2:0] a;
        logic [7:0] din;
        logic [7:0] exp_s;
        logic       exp_v;
        logic       exp_b;
        logic       exp_e;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(string name, logic clear, logic en, logic rw, logic [2:0] a,
                                logic [7:0] din, logic [7:0] es, logic ev, logic eb, logic ee);
        vec_t v;
        v.name = name; v.clear = clear; v.en = en; v.rw = rw; v.a = a; v.din = din;
        v.exp_s = es; v.exp_v = ev; v.exp_b = eb; v.exp_e = ee;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step16(string name, logic clear, logic en, logic rw, logic [2:0] a,
                          logic [15:0] din, logic [15:0] es, logic ev, logic eb, logic ee);
        clr16 = clear; en16 = en; rw16 = rw; a16 = a; din16 = din;
        @(posedge clk);
        #1;
        chk({name, ".s"},     0, 32'(s16), 32'(es));
        chk({name, ".valid"}, 0, 32'(v16), 32'(ev));
        chk({name, ".busy"},  0, 32'(b16), 32'(eb));
        chk({name, ".err"},   0, 32'(e16), 32'(ee));
    endtask

    initial begin
        // Reset held for two edges
        for (int i = 0; i < 2; i++) add("rst", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        // Sweep with a write attempted throughout; busy falls on the 8th edge
        for (int i = 0; i < 8; i++)
            add("sweep", 1'b1, 1'b1, 1'b1, 3'd3, 8'hAA, 8'h00, 1'b0, (i < 7), 1'b0);
        for (int i = 0; i < 8; i++) add("rd0", 1'b1, 1'b1, 1'b0, 3'(i), 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            add("wr1h", 1'b1, 1'b1, 1'b1, 3'(i), 8'(8'h01 << i), 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--)
            add("rd1h", 1'b1, 1'b1, 1'b0, 3'(i), 8'h00, 8'(8'h01 << i), 1'b1, 1'b0, 1'b0);
        add("rd6", 1'b1, 1'b1, 1'b0, 3'd6, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add("idle", 1'b1, 1'b0, 1'b1, 3'd1, 8'h77, 8'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) add("fillff", 1'b1, 1'b1, 1'b1, 3'(i), 8'hFF, 8'h40, 1'b0, 1'b0, 1'b0);
        add("rdff", 1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        // Reset pulse coinciding with a write: the write is discarded
        add("midrst", 1'b0, 1'b1, 1'b1, 3'd2, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            add("resweep", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, (i < 7), 1'b0);
        for (int i = 0; i < 8; i++) add("rdclr", 1'b1, 1'b1, 1'b0, 3'(i), 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            clr8 = vecs[i].clear; en8 = vecs[i].en; rw8 = vecs[i].rw;
            a8 = vecs[i].a; din8 = vecs[i].din;
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".s"},     i, 32'(s8), 32'(vecs[i].exp_s));
            chk({vecs[i].name, ".valid"}, i, 32'(v8), 32'(vecs[i].exp_v));
            chk({vecs[i].name, ".busy"},  i, 32'(b8), 32'(vecs[i].exp_b));
            chk({vecs[i].name, ".err"},   i, 32'(e8), 32'(vecs[i].exp_e));
        end

        // 16 x 5: reset, five-edge sweep, then writes and reads around the unmapped range
        step16("r16", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step16("sw16", 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, (i < 4), 1'b0);
        step16("wr4",   1'b1, 1'b1, 1'b1, 3'd4, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0);
        step16("wr6",   1'b1, 1'b1, 1'b1, 3'd6, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b1);
        step16("idl16", 1'b1, 1'b0, 1'b0, 3'd6, 16'h0,    16'h0, 1'b0, 1'b0, 1'b0);
        step16("rd4",   1'b1, 1'b1, 1'b0, 3'd4, 16'h0, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        step16("rd6",   1'b1, 1'b1, 1'b0, 3'd6, 16'h0, 16'h0000, 1'b1, 1'b0, 1'b1);
        step16("rd4b",  1'b1, 1'b1, 1'b0, 3'd4, 16'h0, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        step16("rd5",   1'b1, 1'b1, 1'b0, 3'd5, 16'h0, 16'h0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step16("rd03", 1'b1, 1'b1, 1'b0, 3'(i), 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
